// File: rtl/sd_decimator_if.sv
// Bitstream-in / PCM-out port bundle for the sigma-delta CIC decimator.
// The master drives the bitstream and the slave (the decimator) returns samples.
interface sd_decimator_if;
    logic               din;
    logic               din_valid;
    logic signed [15:0] dout;
    logic               dout_valid;

    modport master (
        output din,
        output din_valid,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/sd_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, 16-bit signed PCM out.
// Integrators run per consumed bit; a 4-cycle comb pass runs once every R bits.
module sd_decimator #(
    parameter int DECIM_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    sd_decimator_if.slave bus
);
    localparam int W     = 3 * DECIM_LOG2 + 2;
    localparam int SHIFT = 3 * DECIM_LOG2 - 15;
    localparam int SHR   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int XW    = W + 16;

    localparam logic signed [W-1:0]      PLUS_ONE  = W'(1);
    localparam logic signed [W-1:0]      MINUS_ONE = '1;
    localparam logic [DECIM_LOG2-1:0]    CNT_LAST  = '1;
    localparam logic signed [XW-1:0]     Y_MAX     = XW'(32767);
    localparam logic signed [XW-1:0]     Y_MIN     = XW'(-32768);

    typedef enum logic [2:0] {
        IDLE,
        C1,
        C2,
        C3,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0]   x;
    logic signed [W-1:0]   i1, i2, i3, s;
    logic signed [W-1:0]   d1, d2, d3;
    logic signed [W-1:0]   c1, c2, c3;
    logic [DECIM_LOG2-1:0] cnt;
    logic                  capture;
    logic                  ld_c1, ld_c2, ld_c3, ld_out;
    logic signed [XW-1:0]  c3_ext, y_ext;
    logic signed [15:0]    y_sat;

    assign x       = bus.din ? PLUS_ONE : MINUS_ONE;
    assign capture = bus.din_valid && (cnt == CNT_LAST);

    // NOTE: non-blocking assignments make every stage read its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            s   <= '0;
            cnt <= '0;
        end else if (bus.din_valid) begin
            i1  <= i1 + x;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= cnt + DECIM_LOG2'(1);
            if (cnt == CNT_LAST)
                s <= i3 + i2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: assign a default before the case so no path leaves state_nxt unassigned (latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = C1;
            C1:      state_nxt = C2;
            C2:      state_nxt = C3;
            C3:      state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_c1  = 1'b0;
        ld_c2  = 1'b0;
        ld_c3  = 1'b0;
        ld_out = 1'b0;
        case (state)
            C1:      ld_c1  = 1'b1;
            C2:      ld_c2  = 1'b1;
            C3:      ld_c3  = 1'b1;
            OUT:     ld_out = 1'b1;
            default: ;
        endcase
    end

    // Scale to 16 bits; only the positive full-scale code can exceed the range.
    always_comb begin
        c3_ext = XW'(c3);
        y_ext  = (c3_ext <<< SHL) >>> SHR;
        if (y_ext > Y_MAX)
            y_sat = 16'sh7fff;
        else if (y_ext < Y_MIN)
            y_sat = 16'sh8000;
        else
            y_sat = y_ext[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c1             <= '0;
            c2             <= '0;
            c3             <= '0;
            d1             <= '0;
            d2             <= '0;
            d3             <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            if (ld_c1) begin
                c1 <= s - d1;
                d1 <= s;
            end
            if (ld_c2) begin
                c2 <= c1 - d2;
                d2 <= c1;
            end
            if (ld_c3) begin
                c3 <= c2 - d3;
                d3 <= c2;
            end
            if (ld_out)
                bus.dout <= y_sat;
            bus.dout_valid <= ld_out;
        end
    end
endmodule

// File: tb/tb_sd_decimator.sv
// Directed bench for sd_decimator: a per-bit CIC reference model queues each expected
// sample with its due cycle, and a negedge monitor checks value and timing.
module tb_sd_decimator;
    localparam int DL    = 8;
    localparam int R     = 1 << DL;
    localparam int W     = 3 * DL + 2;
    localparam int SHIFT = 3 * DL - 15;
    localparam int TOL   = 655;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sd_decimator_if bus_if ();

    sd_decimator #(.DECIM_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     due;
        bit     has_ref;
        longint lo;
        longint hi;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     edge_cnt = 0;

    longint m_i1, m_i2, m_i3, m_d1, m_d2, m_d3, mod_acc, dc_level;
    int     m_cnt, m_strobe;
    bit     alt_ph;
    bit     use_ref;
    longint ref_lo, ref_hi;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((longint'(1) << W) - 1);
        if (m[W-1]) m = m - (longint'(1) << W);
        return m;
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_i3 = 0;
        m_d1 = 0; m_d2 = 0; m_d3 = 0;
        m_cnt = 0; m_strobe = 0;
        mod_acc = 0; alt_ph = 1'b1;
        sb.delete();
    endtask

    task automatic model_consume(input bit b);
        longint xv, c1, c2, c3, y;
        exp_t   e;
        xv   = b ? 1 : -1;
        m_i3 = wrapw(m_i3 + m_i2);
        m_i2 = wrapw(m_i2 + m_i1);
        m_i1 = wrapw(m_i1 + xv);
        if (m_cnt == R - 1) begin
            c1 = wrapw(m_i3 - m_d1); m_d1 = m_i3;
            c2 = wrapw(c1 - m_d2);   m_d2 = c1;
            c3 = wrapw(c2 - m_d3);   m_d3 = c2;
            y  = c3 >>> SHIFT;
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            m_strobe++;
            e.val     = y;
            e.due     = edge_cnt + 5;
            e.has_ref = use_ref && (m_strobe >= 3);
            e.lo      = ref_lo;
            e.hi      = ref_hi;
            sb.push_back(e);
        end
        m_cnt = (m_cnt + 1) % R;
    endtask

    task automatic step(input bit r, input bit b, input bit v);
        rst              = r;
        bus_if.din       = b;
        bus_if.din_valid = v;
        if (r) model_reset();
        else if (v) model_consume(b);
        @(negedge clk);
    endtask

    task automatic gen_bit(input int mode, output bit b);
        case (mode)
            0: b = 1'b1;
            1: b = 1'b0;
            2: begin b = alt_ph; alt_ph = ~alt_ph; end
            default: begin
                b = (mod_acc >= 0);
                mod_acc = mod_acc + dc_level - (b ? 32768 : -32768);
            end
        endcase
    endtask

    task automatic run(input int mode, input int nbits, input int gap_pct);
        int sent = 0;
        bit b;
        while (sent < nbits) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                step(1'b0, 1'($urandom_range(1)), 1'b0);
            end else begin
                gen_bit(mode, b);
                step(1'b0, b, 1'b1);
                sent++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 1'b0, 1'b0);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    task automatic set_ref(input bit en, input longint lo, input longint hi);
        use_ref = en; ref_lo = lo; ref_hi = hi;
    endtask

    // Scoreboard monitor: strobe value, strobe timing, spacing and missed strobes.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && edge_cnt > sb[0].due) begin
            check("strobe_missing", edge_cnt, sb[0].due);
            void'(sb.pop_front());
        end
        if (bus_if.dout_valid === 1'b1) begin
            check("no_back_to_back", prev_v, 0);
            check("strobe_pending", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("strobe_cycle", edge_cnt, e.due);
                check("dout_model", bus_if.dout, e.val);
                if (e.has_ref)
                    check("dout_ref", (bus_if.dout >= e.lo && bus_if.dout <= e.hi), 1);
            end
        end
        prev_v = bus_if.dout_valid;
    end

    initial begin
        bus_if.din       = 1'b0;
        bus_if.din_valid = 1'b0;
        set_ref(1'b0, 0, 0);
        dc_level = 0;

        // Reset held with random inputs: outputs stay cleared.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("rst_dout", bus_if.dout, 0);
            check("rst_valid", bus_if.dout_valid, 0);
        end

        // All ones: saturates to +32767.
        set_ref(1'b1, 32767, 32767);
        run(0, 6 * R, 0);
        drain();

        // Reset during C2 of the next pass: that pass is discarded.
        run(0, R + 1, 0);
        step(1'b1, 1'b1, 1'b1);
        check("midrst_dout", bus_if.dout, 0);
        check("midrst_valid", bus_if.dout_valid, 0);
        run(0, 5 * R, 0);
        drain();

        // All zeros: exactly -32768.
        do_reset(2);
        set_ref(1'b1, -32768, -32768);
        run(1, 5 * R, 0);
        drain();

        // Alternating bits: zero.
        do_reset(2);
        set_ref(1'b1, 0, 0);
        run(2, 5 * R, 0);
        drain();

        // Modulated +10000 with random 50% gaps.
        do_reset(2);
        dc_level = 10000;
        set_ref(1'b1, dc_level - TOL, dc_level + TOL);
        run(3, 5 * R, 50);
        drain();

        // Modulated -10000, continuous.
        do_reset(2);
        dc_level = -10000;
        set_ref(1'b1, dc_level - TOL, dc_level + TOL);
        run(3, 4 * R, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
